// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port control slice.
package rf_ctrl_pkg;
  localparam int REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;
  localparam int WB_DATA_LEN = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0]   dest;
    logic [WB_DATA_LEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_BUF} grant_src_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO holding multicycle write-back results; entry type is a parameter.
module rf_wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between WB and a buffered multicycle unit,
// with a pending scoreboard. Optional same-cycle bypass: define RF_WB_BYPASS_EN.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int NUM_REGS  = 15,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [3:0]           wb_dest,
  input  logic [DATA_LEN-1:0]  wb_data,
  output logic                 wb_ready,
  input  logic                 mc_issue,
  input  logic [3:0]           mc_issue_dest,
  input  logic                 mc_valid,
  input  logic [3:0]           mc_dest,
  input  logic [DATA_LEN-1:0]  mc_data,
  output logic                 mc_ready,
  output logic                 rf_we,
  output logic [3:0]           rf_dest,
  output logic [DATA_LEN-1:0]  rf_data,
  output logic [NUM_REGS-1:0]  pending
);
  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_LEN-1:0]  data;
  } entry_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  entry_t              mc_entry, head, sel;
  logic                full, empty, push, starve;
  logic                grant_wb, grant_buf, grant_byp;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [NUM_REGS-1:0] pending_nxt;
  grant_src_t          src;

  assign mc_entry = '{dest: mc_dest, data: mc_data};

  rf_wb_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (grant_buf),
    .wr_entry (mc_entry),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign starve    = (wait_cnt == WAIT_W'(MAX_WAIT)) && !empty;
  assign grant_wb  = wb_valid && !starve;
  assign grant_buf = !empty && (!wb_valid || starve);
`ifdef RF_WB_BYPASS_EN
  assign grant_byp = empty && mc_valid && !wb_valid;
`else
  assign grant_byp = 1'b0;
`endif
  assign wb_ready  = !starve;
  assign mc_ready  = !full;
  assign push      = mc_valid && !full && !grant_byp;

  always_comb begin
    src = SRC_NONE;
    sel = '0;
    if (grant_wb) begin
      src = SRC_WB;
      sel = '{dest: wb_dest, data: wb_data};
    end else if (grant_buf) begin
      src = SRC_BUF;
      sel = head;
    end else if (grant_byp) begin
      src = SRC_BUF;
      sel = mc_entry;
    end
  end

  // Clear is applied before set so a same-cycle issue to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if ((grant_buf || grant_byp) && sel.dest != PC_IDX) pending_nxt[sel.dest] = 1'b0;
    if (mc_issue && mc_issue_dest != PC_IDX) pending_nxt[mc_issue_dest] = 1'b1;
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (empty || grant_buf)                 wait_cnt_nxt = '0;
    else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt_nxt = wait_cnt + 1'b1;
  end

  // Registered write port: one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_dest  <= '0;
      rf_data  <= '0;
      pending  <= '0;
      wait_cnt <= '0;
    end else begin
      rf_we    <= (src != SRC_NONE) && (sel.dest != PC_IDX);
      if (src != SRC_NONE) begin
        rf_dest <= sel.dest;
        rf_data <= sel.data;
      end
      pending  <= pending_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus random traffic
// against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int DL = 32;
  localparam int NR = 15;
  localparam int BD = 2;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, wb_ready, mc_issue, mc_valid, mc_ready, rf_we;
  logic [3:0]    wb_dest, mc_issue_dest, mc_dest, rf_dest;
  logic [DL-1:0] wb_data, mc_data, rf_data;
  logic [NR-1:0] pending;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_LEN(DL), .NUM_REGS(NR), .BUF_DEPTH(BD), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .mc_issue(mc_issue), .mc_issue_dest(mc_issue_dest),
    .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .pending(pending)
  );

  typedef struct {
    logic [3:0]    dest;
    logic [DL-1:0] data;
  } ent_t;

  int            tests = 0;
  int            fails = 0;
  ent_t          q[$];
  ent_t          wlog[$];
  int            m_wait;
  logic [NR-1:0] m_pend;
  logic          m_we;
  logic [3:0]    m_dest;
  logic [DL-1:0] m_data;
  logic          s_wb_ready = 1'b1;
  logic          s_mc_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_dest = 0; wb_data = 0;
    mc_issue = 0; mc_issue_dest = 0;
    mc_valid = 0; mc_dest = 0; mc_data = 0;
  endtask

  // One clock: check handshakes against the model, advance model, check registered outputs.
  task automatic step();
    bit   empty, full, starve, gwb, gbuf, gbyp, any;
    ent_t sel;
    #1;
    empty  = (q.size() == 0);
    full   = (q.size() == BD);
    starve = (m_wait == MW) && !empty;
    s_wb_ready = wb_ready;
    s_mc_ready = mc_ready;
    chk("wb_ready", 64'(wb_ready), 64'(!starve));
    chk("mc_ready", 64'(mc_ready), 64'(!full));
    gwb  = wb_valid && !starve;
    gbuf = !empty && (!wb_valid || starve);
    gbyp = 0;
`ifdef RF_WB_BYPASS_EN
    gbyp = empty && mc_valid && !wb_valid;
`endif
    any = 1;
    sel = '{dest: 4'd0, data: '0};
    if (gwb)       sel = '{dest: wb_dest, data: wb_data};
    else if (gbuf) sel = q[0];
    else if (gbyp) sel = '{dest: mc_dest, data: mc_data};
    else           any = 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_wait = 0; m_pend = '0; m_we = 0; m_dest = 0; m_data = 0;
    end else begin
      m_we = any && (sel.dest != 4'd15);
      if (any) begin
        m_dest = sel.dest;
        m_data = sel.data;
      end
      if (m_we) wlog.push_back(sel);
      if ((gbuf || gbyp) && sel.dest != 4'd15) m_pend[sel.dest] = 1'b0;
      if (mc_issue && mc_issue_dest != 4'd15) m_pend[mc_issue_dest] = 1'b1;
      if (empty || gbuf)   m_wait = 0;
      else if (m_wait < MW) m_wait++;
      if (gbuf) void'(q.pop_front());
      if (mc_valid && !full && !gbyp) q.push_back('{dest: mc_dest, data: mc_data});
    end
    #1;
    chk("rf_we",   64'(rf_we),   64'(m_we));
    chk("rf_dest", 64'(rf_dest), 64'(m_dest));
    chk("rf_data", 64'(rf_data), 64'(m_data));
    chk("pending", 64'(pending), 64'(m_pend));
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int   got;
    bit   accepted;
    logic [3:0]    exp_d [3];
    logic [DL-1:0] exp_v [3];

    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete(); m_wait = 0; m_pend = '0; m_we = 0; m_dest = 0; m_data = 0;
    #1;
    chk("reset_rf_we",    64'(rf_we),    64'd0);
    chk("reset_rf_dest",  64'(rf_dest),  64'd0);
    chk("reset_rf_data",  64'(rf_data),  64'd0);
    chk("reset_pending",  64'(pending),  64'd0);
    chk("reset_mc_ready", 64'(mc_ready), 64'd1);
    @(negedge clk);

    // Primary write goes straight through.
    wb_valid = 1; wb_dest = 4'd3; wb_data = 32'hA5;
    step();
    chk("wb_basic_ready", 64'(s_wb_ready), 64'd1);
    chk("wb_basic_we",    64'(rf_we),   64'd1);
    chk("wb_basic_dest",  64'(rf_dest), 64'd3);
    chk("wb_basic_data",  64'(rf_data), 64'hA5);

    // Issue, then buffered result with two-cycle latency clearing pending.
    idle(); mc_issue = 1; mc_issue_dest = 4'd5;
    step();
    chk("issue5_pending", 64'(pending), 64'h0020);
    idle(); mc_valid = 1; mc_dest = 4'd5; mc_data = 32'h77;
    step();
    chk("mc_push_no_write", 64'(rf_we), 64'd0);
    idle();
    step();
    chk("mc_we",      64'(rf_we),   64'd1);
    chk("mc_dest",    64'(rf_dest), 64'd5);
    chk("mc_data",    64'(rf_data), 64'h77);
    chk("mc_pending", 64'(pending), 64'd0);

    // Starvation: buffer entry forced through after MAX_WAIT lost arbitrations.
    idle(); wb_valid = 1; wb_dest = 4'd1; wb_data = 32'd100;
    mc_valid = 1; mc_dest = 4'd2; mc_data = 32'h11;
    step();
    mc_valid = 0;
    for (int k = 1; k <= MW; k++) begin
      wb_data = 32'(100 + k);
      step();
      chk("starve_wb_granted", 64'(s_wb_ready), 64'd1);
    end
    step();
    chk("starve_ready_low", 64'(s_wb_ready), 64'd0);
    chk("starve_buf_dest",  64'(rf_dest), 64'd2);
    chk("starve_buf_data",  64'(rf_data), 64'h11);
    step();
    chk("starve_wb_after_dest", 64'(rf_dest), 64'd1);
    chk("starve_wb_after_data", 64'(rf_data), 64'd104);

    // Fill the buffer while WB is busy; third result waits, order preserved.
    idle(); wlog.delete();
    wb_valid = 1; wb_dest = 4'd1; wb_data = 32'd200;
    mc_valid = 1; mc_dest = 4'd8; mc_data = 32'h81;
    step();
    mc_dest = 4'd9; mc_data = 32'h92;
    step();
    mc_dest = 4'd10; mc_data = 32'hA3;
    step();
    chk("full_mc_ready", 64'(s_mc_ready), 64'd0);
    accepted = 0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      step();
      if (s_mc_ready) accepted = 1;
    end
    chk("third_accepted", 64'(accepted), 64'd1);
    idle();
    repeat (4) step();
    exp_d[0] = 4'd8;  exp_v[0] = 32'h81;
    exp_d[1] = 4'd9;  exp_v[1] = 32'h92;
    exp_d[2] = 4'd10; exp_v[2] = 32'hA3;
    got = 0;
    foreach (wlog[i]) begin
      if (wlog[i].dest >= 4'd8 && wlog[i].dest <= 4'd10 && got < 3) begin
        chk("order_dest", 64'(wlog[i].dest), 64'(exp_d[got]));
        chk("order_data", 64'(wlog[i].data), 64'(exp_v[got]));
        got++;
      end
    end
    chk("order_count", 64'(got), 64'd3);

    // Dest 15 handshake without a write; issue beats clear on the same register.
    idle(); wb_valid = 1; wb_dest = 4'd15; wb_data = 32'h55;
    step();
    chk("pc_ready", 64'(s_wb_ready), 64'd1);
    chk("pc_no_we", 64'(rf_we), 64'd0);
    idle(); mc_valid = 1; mc_dest = 4'd7; mc_data = 32'h70;
    step();
    idle(); mc_issue = 1; mc_issue_dest = 4'd7;
    step();
    chk("setclr_we",   64'(rf_we),      64'd1);
    chk("setclr_dest", 64'(rf_dest),    64'd7);
    chk("setclr_pend", 64'(pending[7]), 64'd1);
    idle(); mc_valid = 1; mc_dest = 4'd7; mc_data = 32'h71;
    step();
    idle();
    step();
    chk("pend7_cleared", 64'(pending), 64'd0);

    // Reset with two buffered entries and outstanding pending bits.
    idle(); mc_issue = 1; mc_issue_dest = 4'd5;
    step();
    mc_issue_dest = 4'd6;
    step();
    idle(); wb_valid = 1; wb_dest = 4'd1; wb_data = 32'd300;
    mc_valid = 1; mc_dest = 4'd5; mc_data = 32'h5;
    step();
    mc_dest = 4'd6; mc_data = 32'h6;
    step();
    chk("pre_reset_pending", 64'(pending), 64'h0060);
    idle(); rst = 1;
    step();
    rst = 0;
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_we",      64'(rf_we),   64'd0);
    #1;
    chk("rst_mc_ready", 64'(mc_ready), 64'd1);
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    @(negedge clk);

    // Random traffic honoring the hold-while-not-ready rules.
    s_wb_ready = 1; s_mc_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!(wb_valid && !s_wb_ready)) begin
        wb_valid = ($urandom_range(0, 99) < 50);
        wb_dest  = 4'($urandom_range(0, 15));
        wb_data  = $urandom;
      end
      if (!(mc_valid && !s_mc_ready)) begin
        mc_valid = ($urandom_range(0, 99) < 40);
        mc_dest  = 4'($urandom_range(0, 15));
        mc_data  = $urandom;
      end
      mc_issue      = ($urandom_range(0, 99) < 30);
      mc_issue_dest = 4'($urandom_range(0, 15));
      rst           = ($urandom_range(0, 299) == 0);
      step();
      if (rst) begin
        s_wb_ready = 1; s_mc_ready = 1;
      end
    end
    rst = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (writeBackEn / Dest_wb / Result_WB) between two requesters:
- the pipeline WB stage (primary);
- a multicycle unit (multiplier/load), which is buffered in a small FIFO.

It also keeps a per-register scoreboard of outstanding multicycle destinations so hazard logic can stall dependent reads. It sits between the WB stage, the multicycle unit and RegisterFile.

Parameters:
- DATA_LEN, 32, datapath width.
- NUM_REGS, 15, register file entries; index 15 (PC) is not stored.
- BUF_DEPTH, 2, multicycle write buffer entries (power of two, ≥2).
- MAX_WAIT, 4, cycles a non-empty buffer may lose arbitration before it is forced through.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  primary write request.
- wb_dest  in  4  primary destination.
- wb_data  in  DATA_LEN  primary data.
- wb_ready  out  1  primary accepted this cycle (combinational).
- mc_issue  in  1  multicycle op issued; marks mc_issue_dest pending.
- mc_issue_dest  in  4  destination of issued op.
- mc_valid  in  1  multicycle result available.
- mc_dest  in  4  result destination.
- mc_data  in  DATA_LEN  result data.
- mc_ready  out  1  buffer not full (combinational).
- rf_we  out  1  to RegisterFile writeBackEn.
- rf_dest  out  4  to Dest_wb.
- rf_data  out  DATA_LEN  to Result_WB.
- pending  out  NUM_REGS  scoreboard; bit i = register i awaiting multicycle result.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - rf_we=0, rf_dest=0, rf_data=0, pending=0.
  - Buffer empty, wait_cnt=0.
  - mc_ready=1 once out of reset.
- Buffer: FIFO of {dest,data}.
  - Push when mc_valid&&mc_ready.
  - mc_ready = !full; no push when full, even if popping the same cycle.
  - Pointers wrap modulo BUF_DEPTH.
- starve = (wait_cnt==MAX_WAIT) && !empty.
- Grants, each cycle:
  - grant_buf = !empty && (!wb_valid || starve).
  - grant_wb = wb_valid && !starve.
  - wb_ready = !starve. The primary must hold wb_* stable while wb_valid && !wb_ready.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) when !empty && !grant_buf.
  - cleared when grant_buf or empty.
- Write port, registered, 1-cycle latency:
  - rf_we <= (grant_wb||grant_buf) && selected dest != 15.
  - rf_dest/rf_data <= the selected source's values.
  - When idle, rf_we <= 0 and rf_dest/rf_data hold.
  - Dest 15 is accepted (handshake completes) but never written.
- Scoreboard:
  - mc_issue sets pending[mc_issue_dest].
  - grant_buf clears pending[head.dest].
  - Same register set and cleared in one cycle: set wins.
  - mc_issue_dest==15: ignored.
  - Primary writes never touch pending.
- Latency:
  - mc result pushed at cycle N is eligible at N+1 (no bypass).
  - With wb idle, rf_we rises after posedge N+2.
- Ordering: buffer entries are written strictly in FIFO order. The primary and buffer are never granted in the same cycle.
- Reset mid-operation: buffered results are discarded and pending is cleared. The multicycle unit is reset by the same rst.

Optional Feature:
RF_WB_BYPASS_EN.
- Defined: when the buffer is empty, mc_valid=1 and wb_valid=0, the result is granted in the same cycle without being pushed. mc_ready stays 1 and pending is cleared identically. Minimum mc latency becomes 1 cycle.
- Undefined: all mc results pass through the buffer (2-cycle minimum).

Decomposition:
- Package rf_ctrl_pkg:
  - REG_IDX_W=4, PC_IDX=15;
  - typedef wb_entry_t {dest[3:0], data[DATA_LEN-1:0]};
  - grant source enum {SRC_NONE, SRC_WB, SRC_BUF}.
- One sub-module, rf_wb_fifo: synchronous FIFO of wb_entry_t with full/empty. The arbiter, counter and scoreboard stay in the top.

Test Plan:
- wb_valid=1, dest=3, data=0xA5 with buffer empty -> wb_ready=1; next cycle rf_we=1, rf_dest=3, rf_data=0xA5.
- mc_issue dest=5 -> pending[5]=1. Later mc_valid dest=5, data=0x77 with wb idle -> rf_we=1, dest=5, data=0x77 two cycles after push, and pending[5]=0 on the same edge.
- Buffer holds one entry and wb_valid held high continuously -> primary granted 4 cycles, then wb_ready=0 for one cycle and the buffer entry is written, wait_cnt=0.
- Fill the buffer (2 pushes) with wb busy -> mc_ready=0. A third mc_valid is held until a pop, and FIFO order of writes is preserved.
- Primary write with dest=15 -> wb_ready=1, rf_we stays 0. mc_issue and grant_buf on reg 7 in the same cycle -> pending[7]=1.
- rst asserted with 2 buffered entries and pending=0x0060 -> after the posedge the buffer is empty, pending=0, rf_we=0, mc_ready=1.
